// File: rtl/apb_fifo_bridge.sv
// apb_fifo_bridge: APB slave bridging the system bus to a byte-stream peripheral
// Ports: clk, reset (sync, active-high); APB paddr/pwdata/prdata/pwrite/psel/penable/pready/pslverr;
//   per_tx_data/per_tx_valid/per_tx_ready drain the TX FIFO; per_rx_data/per_rx_valid feed the RX holding register;
//   irq is the registered interrupt.
module apb_fifo_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h80000000),
  parameter int FIFO_DEPTH = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  input  logic              pwrite,
  input  logic              psel,
  input  logic              penable,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] per_tx_data,
  output logic              per_tx_valid,
  input  logic              per_tx_ready,
  input  logic [DATA_W-1:0] per_rx_data,
  input  logic              per_rx_valid,
  output logic              irq
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nx;
  logic [2:0] wait_cnt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic [DATA_W-1:0] rx_data, status, ctrl, rdata;
  logic rx_valid, rx_ovf, en, irq_en;
  logic hit, done, tx_empty, tx_full, push, pop, rd_clr, w1c, ctrl_wr, err;
  logic [1:0] sel;
  logic [31:0] lvl32;
  assign pready = state == ACCESS && wait_cnt == 3'(WAIT_STATES);
  // only a completed transfer (psel still held) may have side effects
  assign done = pready && psel && penable;
  assign hit = paddr[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4];
  assign sel = 2'(paddr[3:0] >> 2);
  assign tx_empty = level == '0;
  assign tx_full = level == LVL_W'(FIFO_DEPTH);
  assign per_tx_valid = !tx_empty && en;
  assign per_tx_data = mem[rd_ptr];
  assign pop = per_tx_valid && per_tx_ready;
  // full is judged before any same-cycle pop
  assign push = done && hit && pwrite && sel == 2'd0 && !tx_full;
  assign rd_clr = done && hit && !pwrite && sel == 2'd1;
  assign ctrl_wr = done && hit && pwrite && sel == 2'd3;
  assign w1c = ctrl_wr && pwdata[2];
  assign lvl32 = 32'(level);
  always_comb begin
    status = '0;
    status[7:0] = {lvl32 > 32'd15 ? 4'hf : lvl32[3:0], rx_ovf, rx_valid, tx_full, tx_empty};
    ctrl = '0;
    ctrl[1:0] = {irq_en, en};
    rdata = !hit ? '0 : sel == 2'd1 ? rx_data : sel == 2'd2 ? status : sel == 2'd3 ? ctrl : '0;
    err = !hit || (pwrite && (sel == 2'd1 || sel == 2'd2 || (sel == 2'd0 && tx_full)));
    prdata = pready && !pwrite ? rdata : '0;
    pslverr = pready && err;
  end
  always_comb begin
    state_nx = !psel ? IDLE : state == IDLE ? (penable ? IDLE : SETUP) : state == SETUP ? ACCESS : pready ? IDLE : ACCESS;
  end
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : state_nx;
    wait_cnt <= reset || state != ACCESS || pready ? 3'd0 : wait_cnt + 3'd1;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pwdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_ovf <= 1'b0;
      en <= 1'b0;
      irq_en <= 1'b0;
      irq <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      level <= level + LVL_W'(push) - LVL_W'(pop);
      if (per_rx_valid) rx_data <= per_rx_data;
      // a capture racing an RXDATA read keeps the new byte valid without flagging overflow
      rx_valid <= per_rx_valid || (rx_valid && !rd_clr);
      rx_ovf <= (per_rx_valid && rx_valid && !rd_clr) || (rx_ovf && !w1c);
      if (ctrl_wr) {irq_en, en} <= pwdata[1:0];
      irq <= irq_en && (rx_valid || rx_ovf || (en && tx_empty));
    end
  end
endmodule

// File: tb/tb_apb_fifo_bridge.sv
// tb_apb_fifo_bridge: directed self-checking bench for apb_fifo_bridge (WAIT_STATES 0 and 3)
module tb_apb_fifo_bridge;
  logic clk = 0, reset = 1;
  logic [31:0] paddr = 0;
  logic [7:0] pwdata = 0, per_rx_data = 0, rx_data3 = 0;
  logic pwrite = 0, penable = 0, psel0 = 0, psel3 = 0;
  logic per_tx_ready = 0, per_rx_valid = 0, tx_ready3 = 0, rx_valid3 = 0;
  logic [7:0] prdata0, prdata3, tx_data0, tx_data3;
  logic pready0, pready3, pslverr0, pslverr3, tx_valid0, tx_valid3, irq0, irq3;
  int checks = 0, failures = 0, n = 0;
  logic [7:0] rd;
  logic er;
  localparam logic [31:0] TX = 32'h80000000, RX = 32'h80000004, ST = 32'h80000008, CT = 32'h8000000C, BAD = 32'h80000010;
  always #5 clk = ~clk;
  apb_fifo_bridge #(.WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset), .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pwrite(pwrite),
    .psel(psel0), .penable(penable), .pready(pready0), .pslverr(pslverr0), .per_tx_data(tx_data0),
    .per_tx_valid(tx_valid0), .per_tx_ready(per_tx_ready), .per_rx_data(per_rx_data),
    .per_rx_valid(per_rx_valid), .irq(irq0));
  apb_fifo_bridge #(.WAIT_STATES(3)) u3 (
    .clk(clk), .reset(reset), .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pwrite(pwrite),
    .psel(psel3), .penable(penable), .pready(pready3), .pslverr(pslverr3), .per_tx_data(tx_data3),
    .per_tx_valid(tx_valid3), .per_tx_ready(tx_ready3), .per_rx_data(rx_data3),
    .per_rx_valid(rx_valid3), .irq(irq3));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  // act: 0 none, 1 rx strobe on the completion cycle, 2 reset on the completion cycle
  task automatic apb(input int u, input logic [31:0] a, input logic w, input logic [7:0] d, input int act, input logic [7:0] rxd);
    @(negedge clk);
    paddr = a; pwrite = w; pwdata = d; penable = 0;
    if (u == 0) psel0 = 1; else psel3 = 1;
    @(negedge clk);
    penable = 1;
    @(negedge clk);
    n = 0;
    while ((u == 0 ? !pready0 : !pready3) && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("pready_bound", n < 20, 1);
    rd = u == 0 ? prdata0 : prdata3;
    er = u == 0 ? pslverr0 : pslverr3;
    if (act == 1) begin per_rx_valid = 1; per_rx_data = rxd; end
    if (act == 2) reset = 1;
    @(negedge clk);
    psel0 = 0; psel3 = 0; penable = 0; per_rx_valid = 0; reset = 0;
  endtask
  task automatic rx(input logic [7:0] d);
    @(negedge clk);
    per_rx_valid = 1; per_rx_data = d;
    @(negedge clk);
    per_rx_valid = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pready", pready0, 0);
    chk("rst_pslverr", pslverr0, 0);
    chk("rst_prdata", prdata0, 0);
    chk("rst_tx_valid", tx_valid0, 0);
    chk("rst_irq", irq0, 0);
    reset = 0;
    apb(0, ST, 0, 0, 0, 0);
    chk("t1_status", rd, 8'h01);
    chk("t1_latency", n, 0);
    chk("t1_err", er, 0);
    apb(0, CT, 1, 8'h01, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      apb(0, TX, 1, 8'(8'h11 * i), 0, 0);
      chk("t2_push_err", er, 0);
    end
    apb(0, TX, 1, 8'h55, 0, 0);
    chk("t2_full_err", er, 1);
    chk("t2_valid", tx_valid0, 1);
    apb(0, ST, 0, 0, 0, 0);
    chk("t2_status_full", rd, 8'h42);
    @(negedge clk);
    per_tx_ready = 1;
    chk("t2_head0", tx_data0, 8'h11);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      chk("t2_head", tx_data0, 8'(8'h11 * i));
    end
    @(negedge clk);
    per_tx_ready = 0;
    chk("t2_drained", tx_valid0, 0);
    chk("t2_irq_off", irq0, 0);
    apb(0, ST, 0, 0, 0, 0);
    chk("t2_status_empty", rd, 8'h01);
    rx(8'hA5);
    rx(8'h5A);
    apb(0, ST, 0, 0, 0, 0);
    chk("t3_status_ovf", rd, 8'h0D);
    apb(0, RX, 0, 0, 0, 0);
    chk("t3_rxdata", rd, 8'h5A);
    chk("t3_rx_err", er, 0);
    apb(0, CT, 1, 8'h04, 0, 0);
    apb(0, ST, 0, 0, 0, 0);
    chk("t3_status_w1c", rd, 8'h01);
    apb(0, CT, 1, 8'h07, 0, 0);
    apb(0, CT, 0, 0, 0, 0);
    chk("t3_ctrl_rd", rd, 8'h03);
    chk("t3_irq_empty", irq0, 1);
    apb(0, BAD, 0, 0, 0, 0);
    chk("t3_miss_err", er, 1);
    chk("t3_miss_data", rd, 0);
    rx(8'h66);
    apb(0, RX, 0, 0, 1, 8'h77);
    chk("t4_old_byte", rd, 8'h66);
    apb(0, ST, 0, 0, 0, 0);
    chk("t4_status", rd, 8'h05);
    apb(0, RX, 0, 0, 0, 0);
    chk("t4_new_byte", rd, 8'h77);
    apb(0, ST, 0, 0, 0, 0);
    chk("t4_status_clr", rd, 8'h01);
    apb(0, CT, 1, 8'h00, 0, 0);
    per_tx_ready = 1;
    apb(0, TX, 1, 8'h99, 0, 0);
    chk("en_hold_valid", tx_valid0, 0);
    apb(0, ST, 0, 0, 0, 0);
    chk("en_hold_status", rd, 8'h10);
    apb(0, CT, 1, 8'h01, 0, 0);
    chk("en_release_valid", tx_valid0, 1);
    chk("en_release_data", tx_data0, 8'h99);
    @(negedge clk);
    chk("en_popped", tx_valid0, 0);
    per_tx_ready = 0;
    apb(3, ST, 0, 0, 0, 0);
    chk("t5_status", rd, 8'h01);
    chk("t5_latency", n, 3);
    chk("t5_err", er, 0);
    apb(3, BAD, 0, 0, 0, 0);
    chk("t5_miss_err", er, 1);
    apb(3, ST, 1, 8'hFF, 0, 0);
    chk("t5_st_wr_err", er, 1);
    apb(3, ST, 0, 0, 0, 0);
    chk("t5_st_unchanged", rd, 8'h01);
    apb(0, CT, 1, 8'h02, 0, 0);
    apb(0, TX, 1, 8'hA1, 0, 0);
    apb(0, TX, 1, 8'hA2, 0, 0);
    rx(8'h3C);
    @(negedge clk);
    chk("t6_irq_pre", irq0, 1);
    apb(0, TX, 1, 8'hA3, 2, 0);
    chk("t6_pready", pready0, 0);
    chk("t6_irq", irq0, 0);
    chk("t6_tx_valid", tx_valid0, 0);
    apb(0, ST, 0, 0, 0, 0);
    chk("t6_status", rd, 8'h01);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
